// File: rtl/audio_mix_pkg.sv
// ============================================================================
// Module  : audio_mix_pkg
// Brief   : Shared types and widths for the audio sample mixer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_mix_pkg;

  localparam int VOL_W   = 3;
  localparam int SHIFT_W = 2;
  localparam int TONE_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } mix_state_t;

endpackage

`default_nettype wire

// File: rtl/audio_mix_sat.sv
// ============================================================================
// Module  : audio_mix_sat
// Brief   : Signed saturator from IN_W to OUT_W bits, flags clamped values.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_mix_sat #(
  parameter int IN_W  = 31,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  generate
    if (IN_W > OUT_W) begin : g_narrow
      // In range only when every bit above the output sign bit matches it.
      logic [IN_W-OUT_W:0] w_top;
      logic                w_ovf;

      assign w_top = din[IN_W-1:OUT_W-1];
      assign w_ovf = !((&w_top) || (~|w_top));

      always_comb begin
        clip = w_ovf;
        if (w_ovf) begin
          dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                             : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          dout = din[OUT_W-1:0];
        end
      end
    end else begin : g_pass
      assign dout = OUT_W'(din);
      assign clip = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/audio_sample_mixer.sv
// ============================================================================
// Module  : audio_sample_mixer
// Brief   : Sequential NUM_CH-channel PCM mixer with per-channel attenuation,
//           L/R routing, master volume, saturation and sticky status flags.
//           Optional sawtooth test tone when AUDIO_MIX_TONE_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_sample_mixer
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int IN_W   = 24,
  parameter int OUT_W  = 24
) (
  input  logic                            clk_100,
  input  logic                            reset,
  input  logic                            new_sample,
  input  logic [NUM_CH-1:0][IN_W-1:0]     ch_sample,
  input  logic [NUM_CH-1:0]               ch_en_l,
  input  logic [NUM_CH-1:0]               ch_en_r,
  input  logic [NUM_CH-1:0][SHIFT_W-1:0]  ch_shift,
  input  logic [VOL_W-1:0]                master_vol_l,
  input  logic [VOL_W-1:0]                master_vol_r,
  input  logic                            tone_en,
  input  logic                            clear_flags,
  output logic [OUT_W-1:0]                hphone_l,
  output logic [OUT_W-1:0]                hphone_r,
  output logic                            hphone_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic                            clip_l,
  output logic                            clip_r
);

  localparam int ACC_W  = OUT_W + $clog2(NUM_CH) + 4;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = ACC_W + VOL_W + 2;
  localparam int LJ     = OUT_W - IN_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  mix_state_t r_state;
  mix_state_t w_state_nxt;

  logic [NUM_CH-1:0][OUT_W-1:0]   r_snap;
  logic [NUM_CH-1:0]              r_en_l;
  logic [NUM_CH-1:0]              r_en_r;
  logic [NUM_CH-1:0][SHIFT_W-1:0] r_shift;
  logic [VOL_W-1:0]               r_vol_l;
  logic [VOL_W-1:0]               r_vol_r;
  logic [IDX_W-1:0]               r_idx;
  logic signed [ACC_W-1:0]        r_acc_l;
  logic signed [ACC_W-1:0]        r_acc_r;

  logic                           w_load;
  logic                           w_accum;
  logic                           w_scale;
  logic signed [ACC_W-1:0]        w_term;
  logic signed [VOL_W+1:0]        w_gain_l;
  logic signed [VOL_W+1:0]        w_gain_r;
  logic signed [PROD_W-1:0]       w_prod_l;
  logic signed [PROD_W-1:0]       w_prod_r;
  logic signed [ACC_W-1:0]        w_scaled_l;
  logic signed [ACC_W-1:0]        w_scaled_r;
  logic signed [OUT_W-1:0]        w_sat_l;
  logic signed [OUT_W-1:0]        w_sat_r;
  logic                           w_clip_l;
  logic                           w_clip_r;
  logic                           w_tone_sel;
  logic [OUT_W-1:0]               w_tone_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (new_sample) w_state_nxt = ACCUM;
      ACCUM:   if (r_idx == IDX_LAST) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = OUT;
      OUT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_load       = 1'b0;
    w_accum      = 1'b0;
    w_scale      = 1'b0;
    busy         = 1'b1;
    hphone_valid = 1'b0;
    case (r_state)
      IDLE: begin
        busy   = 1'b0;
        w_load = new_sample;
      end
      ACCUM:   w_accum      = 1'b1;
      SCALE:   w_scale      = 1'b1;
      OUT:     hphone_valid = 1'b1;
      default: busy         = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk_100) begin
    if (w_load) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_snap[i] <= OUT_W'($signed(ch_sample[i])) <<< LJ;
      end
      r_en_l  <= ch_en_l;
      r_en_r  <= ch_en_r;
      r_shift <= ch_shift;
      r_vol_l <= master_vol_l;
      r_vol_r <= master_vol_r;
    end
  end

  assign w_term = ACC_W'($signed(r_snap[r_idx])) >>> r_shift[r_idx];

  assign w_gain_l   = signed'({2'b00, r_vol_l} + (VOL_W+2)'(1));
  assign w_gain_r   = signed'({2'b00, r_vol_r} + (VOL_W+2)'(1));
  assign w_prod_l   = PROD_W'(r_acc_l) * PROD_W'(w_gain_l);
  assign w_prod_r   = PROD_W'(r_acc_r) * PROD_W'(w_gain_r);
  assign w_scaled_l = ACC_W'(w_prod_l >>> 3);
  assign w_scaled_r = ACC_W'(w_prod_r >>> 3);

  audio_mix_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (
    .din  (w_scaled_l),
    .dout (w_sat_l),
    .clip (w_clip_l)
  );

  audio_mix_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (
    .din  (w_scaled_r),
    .dout (w_sat_r),
    .clip (w_clip_r)
  );

  // Outputs are registered at the end of SCALE so they are visible while OUT
  // asserts hphone_valid.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_idx    <= '0;
      r_acc_l  <= '0;
      r_acc_r  <= '0;
      hphone_l <= '0;
      hphone_r <= '0;
      overrun  <= 1'b0;
      clip_l   <= 1'b0;
      clip_r   <= 1'b0;
    end else begin
      if (w_load) begin
        r_idx   <= '0;
        r_acc_l <= '0;
        r_acc_r <= '0;
      end else if (w_accum) begin
        r_idx <= r_idx + IDX_W'(1);
        if (r_en_l[r_idx]) r_acc_l <= r_acc_l + w_term;
        if (r_en_r[r_idx]) r_acc_r <= r_acc_r + w_term;
      end

      if (w_scale) begin
        hphone_l <= w_tone_sel ? w_tone_word : w_sat_l;
        hphone_r <= w_tone_sel ? w_tone_word : w_sat_r;
      end

      if (new_sample && (r_state != IDLE)) overrun <= 1'b1;
      else if (clear_flags)                overrun <= 1'b0;

      if (w_scale && !w_tone_sel && w_clip_l) clip_l <= 1'b1;
      else if (clear_flags)                   clip_l <= 1'b0;

      if (w_scale && !w_tone_sel && w_clip_r) clip_r <= 1'b1;
      else if (clear_flags)                   clip_r <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- test tone
`ifdef AUDIO_MIX_TONE_EN
  logic              r_tone;
  logic [TONE_W-1:0] r_tone_cnt;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      r_tone     <= 1'b0;
      r_tone_cnt <= '0;
    end else begin
      if (w_load) r_tone <= tone_en;
      if (w_scale && r_tone) r_tone_cnt <= r_tone_cnt + TONE_W'(1);
    end
  end

  assign w_tone_sel  = r_tone;
  assign w_tone_word = OUT_W'(r_tone_cnt) << (OUT_W - TONE_W);
`else
  logic w_unused_tone;

  assign w_unused_tone = tone_en;
  assign w_tone_sel    = 1'b0;
  assign w_tone_word   = '0;
`endif

endmodule

`default_nettype wire

// File: doc/audio_sample_mixer.md
# audio_sample_mixer

Parametrised final-stage PCM mixer for the GBA audio path, running in the clk_100 domain between the per-channel sound generators (PSG mix, Direct Sound A/B) and the AC codec interface. On each codec `new_sample` strobe it snapshots NUM_CH signed channel samples and accumulates them sequentially, one channel per cycle. Each channel has its own attenuation and left/right routing, and each side has a master volume. The block saturates the result to OUT_W and presents it to the codec as `hphone_l`/`hphone_r` with a one-cycle valid pulse. Sticky flags report clipping and overruns.

## Interface
Parameters:
- NUM_CH, 6, number of input channels (≥1)
- IN_W, 24, channel sample width, signed two's complement
- OUT_W, 24, output width (OUT_W ≥ IN_W); inputs are left-justified by OUT_W−IN_W
- ACC_W (localparam) = OUT_W + $clog2(NUM_CH) + 4, accumulator width

Ports:
- clk_100  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- new_sample  in  1  codec sample strobe, one-cycle pulse
- ch_sample  in  [NUM_CH-1:0][IN_W-1:0]  signed channel samples
- ch_en_l, ch_en_r  in  NUM_CH  per-channel routing to left/right
- ch_shift  in  [NUM_CH-1:0][1:0]  per-channel attenuation, arithmetic >>> 0..3
- master_vol_l, master_vol_r  in  3  side gain (vol+1)/8
- tone_en  in  1  test-tone select (see Configuration)
- clear_flags  in  1  clears the sticky flags
- hphone_l, hphone_r  out  OUT_W  mixed samples, held between updates
- hphone_valid  out  1  one-cycle pulse when hphone_l/r update
- busy  out  1  high whenever state ≠ IDLE
- overrun  out  1  sticky: new_sample arrived while busy
- clip_l, clip_r  out  1  sticky: saturation occurred on that side

## Operation
- States: IDLE → ACCUM → SCALE → OUT → IDLE.
- IDLE + new_sample:
  - snapshot ch_sample (left-justified to OUT_W), en, shift, vol and tone_en into registers
  - clear acc_l/acc_r; idx=0; go to ACCUM
- ACCUM, one cycle per channel:
  - term = snap[idx] >>> shift[idx], sign-extended to ACC_W
  - acc_l += en_l[idx] ? term : 0; acc_r likewise
  - idx==NUM_CH-1 → SCALE, else idx++
- SCALE: acc_x = (acc_x × (vol_x+1)) >>> 3, arithmetic, full ACC_W precision.
- OUT, per side:
  - saturate acc_x to the signed OUT_W range and register it into hphone_x
  - set clip_x if the value was clamped
  - hphone_valid=1 for this cycle; next state IDLE
- new_sample seen in any state other than IDLE: ignored; overrun ← 1.
- Flag clear vs set: clear_flags clears overrun and clip_*. When clear and set coincide in the same cycle, set wins.
- Live input changes after the snapshot do not affect the sample in flight.
- Reset values: state IDLE, hphone_l/r=0, hphone_valid=0, busy=0, all flags 0, tone counter 0.
- Reset mid-operation aborts the sample; no valid pulse is produced for it.

## Timing
- new_sample is sampled at the end of cycle 0.
- ACCUM occupies cycles 1..NUM_CH; SCALE is cycle NUM_CH+1.
- hphone_valid is high in cycle NUM_CH+2; new data is visible in that cycle.
- busy is high in cycles 1..NUM_CH+2.
- Next acceptable strobe: cycle NUM_CH+3.
- At 48 kHz there are ≈2083 clk_100 cycles per sample, so overrun only indicates a fault.

## Configuration
- AUDIO_MIX_TONE_EN defined:
  - a 6-bit sawtooth counter is compiled in
  - when snapshot tone_en=1, OUT drives both sides with {cnt, OUT_W−6 zeros} instead of the mix
  - cnt then increments (first output uses cnt=0, wraps 63→0)
  - latency is unchanged; clip flags are not touched
- Undefined: the counter is absent and tone_en is ignored; the mix is always output.

## Structure
- Package audio_mix_pkg:
  - mix_state_t enum (IDLE, ACCUM, SCALE, OUT)
  - VOL_W=3, SHIFT_W=2, TONE_W=6
- Sub-module audio_mix_sat (parameters IN_W, OUT_W):
  - signed saturator with a clip output
  - instantiated once per side

## Test plan
Defaults unless stated: NUM_CH=6, IN_W=OUT_W=24.
- ch0=0x100000, en_l=6'b000001, en_r=0, shift 0, vol_l=7, pulse new_sample → hphone_l=0x100000, hphone_r=0, valid in cycle 8.
- All six channels 0x7FFFFF, both sides enabled, vol 7 → both outputs 0x7FFFFF, clip_l=clip_r=1. Repeat with 0x800000 → 0x800000.
- ch0=0x400000, shift=2, vol_l=3 → hphone_l=0x080000, clip_l=0.
- Second new_sample 3 cycles after the first → exactly one valid pulse, overrun=1; clear_flags → overrun=0.
- Reset asserted in cycle 4 → next cycle busy=0, outputs 0; no valid pulse follows.
- With AUDIO_MIX_TONE_EN, tone_en=1, three strobes → hphone_l=hphone_r = 0x000000, 0x040000, 0x080000.
